instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the 16-bit processor, the initiator side of the instruction-memory read interface. It drives the word address into `instruction_memory` and captures the returned instruction, together with its PC, into a small prefetch queue. It hands instructions to decode over a valid/ready handshake. Branch redirects from execute flush the queue, and fetch restarts at `branch_pc + sext(offset10)`.

## Interface
- `DEPTH`, default 2: prefetch queue entries (≥1, power of two).
- `RESET_PC`, default 16'h0000: fetch address after reset.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `imem_addr`  out  16: word address to instruction memory.
- `imem_data`  in  16: instruction word. Combinational from `imem_addr`, valid in the same cycle.
- `if_valid`  out  1: queue head holds an instruction.
- `if_ready`  in  1: decode accepts the head this cycle.
- `if_instr`  out  16: head instruction.
- `if_pc`  out  16: head instruction address.
- `redirect_valid`  in  1: taken branch from execute, single-cycle pulse.
- `redirect_pc`  in  16: address of the taken branch.
- `redirect_offset`  in  10: signed word offset, two's complement.

## Operation
- Registers:
  - `fetch_pc`: 16 bits.
  - Queue of DEPTH × {pc[15:0], instr[15:0]}: read/write pointers and a count of 0..DEPTH.
- Wiring:
  - `imem_addr = fetch_pc`, combinational.
  - `if_valid = (count != 0)`.
  - `if_instr`/`if_pc` = head entry.
- Pop: occurs when `if_valid && if_ready`.
- Push: occurs when there is no redirect and (`count < DEPTH` or pop this cycle).
  - The entry pushed is {fetch_pc, imem_data}.
  - `fetch_pc <= fetch_pc + 1`, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- Full with no pop: no push. `fetch_pc` and `imem_addr` hold.
- Redirect has priority over push:
  - Queue cleared: count=0 and pointers reset.
  - `fetch_pc <= redirect_pc + {{6{redirect_offset[9]}}, redirect_offset}`, truncated to 16 bits with wrap.
  - A pop in the same cycle is still a completed handshake. The popped entry counts as delivered; the remaining entries are discarded.
- Redirect while the queue is empty: same behaviour. Fetch of the old `fetch_pc` is dropped.
- The fetch unit never decodes opcodes. It stays opcode-agnostic.
- Reset, at any time including mid-operation, takes effect immediately:
  - `fetch_pc=RESET_PC`, count=0, pointers=0.
  - All queue entries are cleared to 0.
  - Outputs: `if_valid=0`, `if_instr=16'h0000`, `if_pc=16'h0000`, `imem_addr=RESET_PC`.

## Timing
- First cycle after reset release: push of RESET_PC. `if_valid=1` at the next edge. Fetch-to-decode latency is 1 cycle.
- Steady state with `if_ready=1`: one instruction per cycle, count stays 1, `if_pc` increments by 1 each cycle.
- `if_ready=0`:
  - The queue fills in DEPTH cycles.
  - The head is held stable: `if_instr`/`if_pc` must not change while `if_valid && !if_ready`.
- Redirect asserted in cycle N:
  - `if_valid=0` in cycle N+1, while the target is being fetched.
  - Target instruction valid in cycle N+2. Bubble cost: 1 cycle.
- Back-to-back redirects: the last one wins. Each redirect flushes again.

## Structure
- Shared package `cpu_pkg` holds:
  - `ADDR_W=16`, `INSTR_W=16`, `IMM_W=10`.
  - Opcode constants: `OP_ADD=3'b000`, `OP_SUB=3'b001`, `OP_OUT=3'b100`, `OP_LDI=3'b101`, `OP_BNE=3'b110`. These are shared with decode.
  - A fetch-entry struct {pc, instr}.
- One sub-module: `fetch_fifo`.
  - DEPTH-entry synchronous FIFO.
  - Ports: push, pop, flush, full, empty, head.
  - Asynchronous reset.
  - Top level keeps `fetch_pc` and the redirect arithmetic.

## Test plan
- Reset, using the multiply program image:
  - During reset: `imem_addr=0000`, `if_valid=0`.
  - Release with `if_ready=1`: `if_pc` = 0000, 0001, 0002, … on consecutive cycles.
  - `if_instr` at 0000 = 16'hA002.
- Backpressure:
  - Hold `if_ready=0` after reset.
  - count reaches 2, `imem_addr` holds at 0002.
  - `if_pc=0000` stable.
  - Raise ready: 0000 and 0001 delivered, then 0002.
- Branch back:
  - Redirect with pc=0006, offset=10'h3FE.
  - Next valid entry: `if_pc=0004`, `if_instr=16'h0400`.
  - Exactly one invalid cycle in between.
- Redirect with the queue full and a simultaneous pop:
  - Popped entry counted as delivered.
  - Other entry discarded, never presented.
  - Target delivered at N+2.
- Wrap-around:
  - Redirect pc=FFFE, offset=10'h001.
  - `if_pc` sequence FFFF then 0000.
  - Separately, redirect pc=0001, offset=10'h3FE → target FFFF.
- Mid-run reset:
  - Assert reset between clock edges with 2 entries queued.
  - `if_valid`, `if_instr`, `if_pc` go to 0 immediately, and `imem_addr=RESET_PC`.
  - Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor: datapath widths, opcode
// encodings used by decode, and the fetch-queue entry layout.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int IMM_W   = 10;

  // Opcode field (instr[15:13]); fetch never interprets these, decode does.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_BNE = 3'b110;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Branch target: base address plus sign-extended word offset, wrapping mod 2^16.
  function automatic logic [ADDR_W-1:0] branch_target(
    input logic [ADDR_W-1:0] base,
    input logic [IMM_W-1:0]  offset
  );
    return base + {{(ADDR_W-IMM_W){offset[IMM_W-1]}}, offset};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue between the instruction memory and decode. A DEPTH-entry
// synchronous FIFO of {pc, instr} with a single-cycle flush used on redirects.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pointer advance with explicit wrap so any DEPTH, including 1, works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  // Storage, pointers and occupancy; flush empties the queue in one cycle.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage array is reset too, so the head reads as zero
      // straight out of reset; this costs a reset net on every entry.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction-memory address, queues returned words
// with their PC, and hands them to decode over valid/ready. A taken branch
// from execute flushes the queue and restarts fetch at the branch target.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int               DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [IMM_W-1:0]   redirect_offset
);

  logic [ADDR_W-1:0] r_fetch_pc;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  // Memory is combinational, so the word for fetch_pc is available this cycle.
  assign imem_addr    = r_fetch_pc;
  assign w_push_entry = '{pc: r_fetch_pc, instr: imem_data};

  assign if_valid = !w_empty;
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;

  // A pop alongside a redirect is still a delivered instruction; the rest of
  // the queue and the in-flight fetch are wrong-path and are dropped.
  assign w_pop  = if_valid && if_ready;
  assign w_push = !redirect_valid && (!w_full || w_pop);

  // Fetch address: redirect wins, otherwise advance only when the word was queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= branch_target(redirect_pc, redirect_offset);
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .push_entry (w_push_entry),
    .full       (w_full),
    .empty      (w_empty),
    .head       (w_head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a combinational program image
// feeds the DUT, and a scoreboard of expected {pc, instr} deliveries is
// compared against each completed valid/ready handshake.
module tb_instruction_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [9:0]  redirect_offset;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  instruction_fetch #(
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_offset (redirect_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiply program image; addresses outside it return a recognisable pattern.
  function automatic logic [15:0] imem_model(input logic [15:0] a);
    case (a)
      16'h0000: return {OP_LDI, 13'h0002};
      16'h0001: return {OP_LDI, 13'h0203};
      16'h0002: return {OP_LDI, 13'h0400};
      16'h0003: return {OP_ADD, 13'h0088};
      16'h0004: return {OP_ADD, 13'h0400};
      16'h0005: return {OP_SUB, 13'h0121};
      16'h0006: return {OP_BNE, 3'b010, 10'h3FE};
      16'h0007: return {OP_OUT, 13'h0100};
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  always_comb imem_data = imem_model(imem_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = imem_model(pc);
    sb.push_back(e);
  endtask

  // Called at a negedge once if_ready is set: checks the handshake that the next edge completes.
  task automatic observe();
    exp_t e;
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_delivery: got pc %h instr %h, scoreboard empty", if_pc, if_instr);
      end else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr)
          $display("FAIL delivery: got pc %h instr %h, want pc %h instr %h", if_pc, if_instr, e.pc, e.instr);
        else
          pass_cnt++;
      end
    end
  endtask

  task automatic check_drained(input string name);
    chk_cnt++;
    if (sb.size() != 0)
      $display("FAIL %s_drain: %0d expected deliveries never seen, want 0", name, sb.size());
    else
      pass_cnt++;
  endtask

  task automatic do_reset(input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    redirect_offset = '0;
    if_ready       = rdy;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    tick();
    chk_cnt++;
    if (imem_addr !== 16'h0000 || if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 16'h0000)
      $display("FAIL reset_state: got addr %h valid %b instr %h pc %h, want 0000 0 0000 0000", imem_addr, if_valid, if_instr, if_pc);
    else pass_cnt++;
    do_reset(1'b1);
    chk_cnt++;
    if (if_valid !== 1'b0) $display("FAIL reset_first_cycle_valid: got %b want 0", if_valid);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) push_exp(16'(i));
    tick();
    chk_cnt++;
    if (if_valid !== 1'b1 || if_instr !== 16'hA002)
      $display("FAIL reset_first_instr: got valid %b instr %h, want 1 a002", if_valid, if_instr);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      observe();
      tick();
    end
    check_drained("reset");
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    tick();
    tick();
    tick();
    chk_cnt++;
    if (imem_addr !== 16'h0002 || if_pc !== 16'h0000 || if_valid !== 1'b1)
      $display("FAIL bp_full: got addr %h pc %h valid %b, want 0002 0000 1", imem_addr, if_pc, if_valid);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (if_pc !== 16'h0000 || if_instr !== 16'hA002 || imem_addr !== 16'h0002)
        $display("FAIL bp_hold: got pc %h instr %h addr %h, want 0000 a002 0002", if_pc, if_instr, imem_addr);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      observe();
      tick();
    end
    check_drained("bp");
  endtask

  task automatic test_branch_back();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    tick();
    for (int i = 0; i < 3; i++) begin
      observe();
      tick();
    end
    redirect_valid  = 1'b1;
    redirect_pc     = 16'h0006;
    redirect_offset = 10'h3FE;
    observe();
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_addr !== 16'h0004)
      $display("FAIL branch_bubble: got valid %b addr %h, want 0 0004", if_valid, imem_addr);
    else pass_cnt++;
    for (int i = 4; i < 7; i++) push_exp(16'(i));
    tick();
    chk_cnt++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0004 || if_instr !== 16'h0400)
      $display("FAIL branch_target: got valid %b pc %h instr %h, want 1 0004 0400", if_valid, if_pc, if_instr);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      observe();
      tick();
    end
    check_drained("branch");
  endtask

  task automatic test_redirect_full_pop();
    do_reset(1'b0);
    tick();
    tick();
    tick();
    push_exp(16'h0000);
    if_ready        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 16'h0010;
    redirect_offset = 10'h005;
    observe();
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_addr !== 16'h0015)
      $display("FAIL fullpop_bubble: got valid %b addr %h, want 0 0015", if_valid, imem_addr);
    else pass_cnt++;
    observe();
    push_exp(16'h0015);
    push_exp(16'h0016);
    tick();
    chk_cnt++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0015)
      $display("FAIL fullpop_target: got valid %b pc %h, want 1 0015", if_valid, if_pc);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      observe();
      tick();
    end
    check_drained("fullpop");
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    tick();
    redirect_valid  = 1'b1;
    redirect_pc     = 16'hFFFE;
    redirect_offset = 10'h001;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_addr !== 16'hFFFF)
      $display("FAIL wrap_fwd_bubble: got valid %b addr %h, want 0 ffff", if_valid, imem_addr);
    else pass_cnt++;
    if_ready = 1'b1;
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    push_exp(16'h0001);
    tick();
    for (int i = 0; i < 3; i++) begin
      observe();
      tick();
    end
    check_drained("wrap_fwd");
    if_ready        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 16'h0001;
    redirect_offset = 10'h3FE;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_addr !== 16'hFFFF)
      $display("FAIL wrap_back_bubble: got valid %b addr %h, want 0 ffff", if_valid, imem_addr);
    else pass_cnt++;
    if_ready = 1'b1;
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      observe();
      tick();
    end
    check_drained("wrap_back");
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    tick();
    redirect_valid  = 1'b1;
    redirect_pc     = 16'h0100;
    redirect_offset = 10'h000;
    tick();
    redirect_pc     = 16'h0200;
    redirect_offset = 10'h010;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_addr !== 16'h0100)
      $display("FAIL b2b_first: got valid %b addr %h, want 0 0100", if_valid, imem_addr);
    else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_addr !== 16'h0210)
      $display("FAIL b2b_second: got valid %b addr %h, want 0 0210", if_valid, imem_addr);
    else pass_cnt++;
    if_ready = 1'b1;
    push_exp(16'h0210);
    push_exp(16'h0211);
    tick();
    for (int i = 0; i < 2; i++) begin
      observe();
      tick();
    end
    check_drained("b2b");
  endtask

  task automatic test_midrun_reset();
    do_reset(1'b0);
    tick();
    tick();
    chk_cnt++;
    if (if_valid !== 1'b1 || imem_addr !== 16'h0002)
      $display("FAIL mid_pre: got valid %b addr %h, want 1 0002", if_valid, imem_addr);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 16'h0000 || imem_addr !== 16'h0000)
      $display("FAIL mid_reset: got valid %b instr %h pc %h addr %h, want 0 0000 0000 0000", if_valid, if_instr, if_pc, imem_addr);
    else pass_cnt++;
    @(negedge clk);
    reset    = 1'b0;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(16'(i));
    tick();
    chk_cnt++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000)
      $display("FAIL mid_restart: got valid %b pc %h, want 1 0000", if_valid, if_pc);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      observe();
      tick();
    end
    check_drained("mid");
  endtask

  initial begin
    reset           = 1'b1;
    if_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    redirect_offset = '0;
    @(negedge clk);
    test_reset();
    test_backpressure();
    test_branch_back();
    test_redirect_full_pop();
    test_wrap();
    test_back_to_back();
    test_midrun_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
